dtfag_seq_ctrl: RTL and testbench



---
 rtl/dtfag_pkg.sv | 19 +
 rtl/dtfag_stage_cnt.sv | 58 +++++
 rtl/dtfag_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dtfag_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dtfag_pkg.sv
// Shared definitions for the DTFAG twiddle-factor sequencer: FSM state codes,
// multiplier-A mux select codes and the counter width helper.
package dtfag_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [1:0] MUL_SEL_ZERO = 2'd0;
    localparam logic [1:0] MUL_SEL_PASS = 2'd1;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int dtfag_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dtfag_stage_cnt.sv
// Nested twiddle-index / stage counter. Holds the index of the next twiddle
// to issue and flags when that issue is the last one of the pass.
module dtfag_stage_cnt
    import dtfag_pkg::*;
#(
    parameter int STAGE_NUM     = 4,
    parameter int CYC_PER_STAGE = 256,
    parameter int STG_W         = dtfag_clog2(STAGE_NUM),
    parameter int CNT_W         = dtfag_clog2(CYC_PER_STAGE)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] tw_cnt_o,
    output logic [STG_W-1:0] stage_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic             cnt_wrap;
    logic             stg_last;

    assign cnt_wrap = (cnt_q == CNT_W'(CYC_PER_STAGE - 1));
    assign stg_last = (stg_q == STG_W'(STAGE_NUM - 1));

    always_comb begin
        cnt_d = cnt_q;
        stg_d = stg_q;
        if (clr_i) begin
            cnt_d = '0;
            stg_d = '0;
        end else if (en_i) begin
            if (cnt_wrap) begin
                cnt_d = '0;
                stg_d = stg_last ? '0 : stg_q + STG_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            stg_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            stg_q <= stg_d;
        end
    end

    assign tw_cnt_o = cnt_q;
    assign stage_o  = stg_q;
    assign last_o   = cnt_wrap && stg_last;

endmodule

// File: rtl/dtfag_seq_ctrl.sv
// Pass sequencer for the DTFAG twiddle path: load, staged issue with stall,
// pipeline flush, done pulse. Every output is a register.
//
//   state | meaning
//   IDLE  | waiting for start, all outputs low
//   LOAD  | generator seeds base registers (load_en), LOAD_CYC cycles
//   RUN   | one twiddle issued per unstalled cycle
//   FLUSH | drain PIPE_LAT multiplier stages, mux forced to zero
//   DONE  | one-cycle done pulse, busy still high
module dtfag_seq_ctrl
    import dtfag_pkg::*;
#(
    parameter int STAGE_NUM     = 4,
    parameter int CYC_PER_STAGE = 256,
    parameter int LOAD_CYC      = 2,
    parameter int PIPE_LAT      = 3,
    parameter int STG_W         = dtfag_clog2(STAGE_NUM),
    parameter int CNT_W         = dtfag_clog2(CYC_PER_STAGE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ifft_mode,
    input  logic             stall,
    output logic [1:0]       Mul_sel,
    output logic [STG_W-1:0] stage_idx,
    output logic [CNT_W-1:0] tw_cnt,
    output logic             tw_valid,
    output logic             load_en,
    output logic             ifft_r,
    output logic             busy,
    output logic             done
);

    localparam int LD_W = dtfag_clog2(LOAD_CYC);
    localparam int FL_W = dtfag_clog2(PIPE_LAT);
    localparam logic [LD_W-1:0] LD_INIT = LD_W'(LOAD_CYC - 1);
    localparam logic [FL_W-1:0] FL_INIT = FL_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    logic [2:0]       state_q, state_d;
    logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [1:0]       mul_sel_q, mul_sel_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic [CNT_W-1:0] tw_cnt_q, tw_cnt_d;
    logic             tw_valid_q, tw_valid_d;
    logic             load_en_q, load_en_d;
    logic             ifft_q, ifft_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_clr, cnt_en, cnt_last;
    logic [CNT_W-1:0] nxt_cnt;
    logic [STG_W-1:0] nxt_stg;

    dtfag_stage_cnt #(
        .STAGE_NUM     (STAGE_NUM),
        .CYC_PER_STAGE (CYC_PER_STAGE),
        .STG_W         (STG_W),
        .CNT_W         (CNT_W)
    ) u_stage_cnt (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .tw_cnt_o (nxt_cnt),
        .stage_o  (nxt_stg),
        .last_o   (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ifft_d      = ifft_q;
        busy_d      = busy_q;
        mul_sel_d   = MUL_SEL_ZERO;
        tw_valid_d  = 1'b0;
        load_en_d   = 1'b0;
        done_d      = 1'b0;
        tw_cnt_d    = '0;
        stage_d     = '0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                ifft_d = 1'b0;
                // busy_q is still high during the visible done cycle, so a
                // start landing there is dropped.
                if (start && !busy_q) begin
                    state_d  = LOAD;
                    ifft_d   = ifft_mode;
                    busy_d   = 1'b1;
                    ld_cnt_d = LD_INIT;
                end
            end
            LOAD: begin
                load_en_d = 1'b1;
                if (ld_cnt_q == '0) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end else begin
                    ld_cnt_d = ld_cnt_q - LD_W'(1);
                end
            end
            RUN: begin
                tw_cnt_d = tw_cnt_q;
                stage_d  = stage_q;
                if (!stall) begin
                    mul_sel_d  = MUL_SEL_PASS;
                    tw_valid_d = 1'b1;
                    tw_cnt_d   = nxt_cnt;
                    stage_d    = nxt_stg;
                    cnt_en     = 1'b1;
                    if (cnt_last) begin
                        if (PIPE_LAT == 0) begin
                            state_d = DONE;
                        end else begin
                            state_d     = FLUSH;
                            flush_cnt_d = FL_INIT;
                        end
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FL_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            flush_cnt_q <= '0;
            mul_sel_q   <= MUL_SEL_ZERO;
            stage_q     <= '0;
            tw_cnt_q    <= '0;
            tw_valid_q  <= 1'b0;
            load_en_q   <= 1'b0;
            ifft_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mul_sel_q   <= mul_sel_d;
            stage_q     <= stage_d;
            tw_cnt_q    <= tw_cnt_d;
            tw_valid_q  <= tw_valid_d;
            load_en_q   <= load_en_d;
            ifft_q      <= ifft_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Mul_sel   = mul_sel_q;
    assign stage_idx = stage_q;
    assign tw_cnt    = tw_cnt_q;
    assign tw_valid  = tw_valid_q;
    assign load_en   = load_en_q;
    assign ifft_r    = ifft_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dtfag_seq_ctrl.sv
// Directed bench for dtfag_seq_ctrl: per-cycle expected outputs are queued as
// stimulus is driven and checked on the falling edge; a PIPE_LAT=0 copy checks timing.
module tb_dtfag_seq_ctrl;

    localparam int SN  = 2;
    localparam int CPS = 4;
    localparam int LC  = 2;
    localparam int PL  = 3;

    typedef struct packed {
        logic [1:0] ms;
        logic       stg;
        logic [1:0] cnt;
        logic       v;
        logic       ld;
        logic       ifft;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        string tag;
        exp_t  v;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    logic       ifft_mode = 1'b0;
    logic       stall = 1'b0;

    logic [1:0] Mul_sel, Mul_sel0;
    logic [0:0] stage_idx, stage_idx0;
    logic [1:0] tw_cnt, tw_cnt0;
    logic       tw_valid, load_en, ifft_r, busy, done;
    logic       tw_valid0, load_en0, ifft_r0, busy0, done0;

    int n_tests = 0;
    int n_fail  = 0;
    int pcnt = 0;
    int iss = 0, n_done = 0, done_edge = 0;
    int iss0 = 0, n_done0 = 0, done0_edge = 0, last_v0 = 0;
    sb_t sb[$];

    dtfag_seq_ctrl #(
        .STAGE_NUM(SN), .CYC_PER_STAGE(CPS), .LOAD_CYC(LC), .PIPE_LAT(PL),
        .STG_W(1), .CNT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ifft_mode(ifft_mode), .stall(stall),
        .Mul_sel(Mul_sel), .stage_idx(stage_idx), .tw_cnt(tw_cnt), .tw_valid(tw_valid),
        .load_en(load_en), .ifft_r(ifft_r), .busy(busy), .done(done)
    );

    dtfag_seq_ctrl #(
        .STAGE_NUM(SN), .CYC_PER_STAGE(CPS), .LOAD_CYC(LC), .PIPE_LAT(0),
        .STG_W(1), .CNT_W(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .ifft_mode(ifft_mode), .stall(stall),
        .Mul_sel(Mul_sel0), .stage_idx(stage_idx0), .tw_cnt(tw_cnt0), .tw_valid(tw_valid0),
        .load_en(load_en0), .ifft_r(ifft_r0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcnt++;

    always @(negedge clk) begin
        exp_t o;
        sb_t  e;
        if (tw_valid === 1'b1) iss++;
        if (done === 1'b1) begin
            n_done++;
            done_edge = pcnt;
        end
        if (tw_valid0 === 1'b1) begin
            iss0++;
            last_v0 = pcnt;
        end
        if (done0 === 1'b1) begin
            n_done0++;
            done0_edge = pcnt;
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            o = '{Mul_sel, stage_idx[0], tw_cnt, tw_valid, load_en, ifft_r, busy, done};
            n_tests++;
            assert (o === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed ms/stg/cnt/v/ld/ifft/busy/done=%b expected %b",
                       e.tag, o, e.v);
            end
        end
    end

    function automatic exp_t mk(input logic [1:0] ms, input int stg, input int cnt,
                                input logic v, input logic ld, input logic ifft,
                                input logic bsy, input logic dn);
        exp_t x;
        x.ms   = ms;
        x.stg  = stg[0];
        x.cnt  = cnt[1:0];
        x.v    = v;
        x.ld   = ld;
        x.ifft = ifft;
        x.busy = bsy;
        x.done = dn;
        return x;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive inputs for the next rising edge and queue the outputs expected after it.
    task automatic step(input logic st, input logic sl, input logic rn,
                        input string tag, input exp_t e);
        sb_t s;
        start = st;
        stall = sl;
        rst_n = rn;
        s.tag = tag;
        s.v   = e;
        sb.push_back(s);
        @(posedge clk);
        #1;
    endtask

    // One pass from the start edge (e=0). Stall covers edges [st_from, st_from+st_len)
    // of RUN; stall_lf holds stall high on every non-RUN edge; poke fires ignored
    // starts in LOAD, RUN and the done cycle; abort_e >= 0 pulls reset at that edge.
    task automatic pass(input logic ifft, input int st_from, input int st_len,
                        input logic stall_lf, input logic poke, input int abort_e,
                        input string name);
        int   issued = 0;
        int   fl = 0;
        int   e = 0;
        int   lst = 0;
        int   lcn = 0;
        int   nd0;
        int   start_edge;
        bit   fin = 1'b0;
        bit   dn_seen = 1'b0;
        logic st, sl;
        exp_t x;
        nd0 = n_done;
        iss = 0;
        ifft_mode = ifft;
        start_edge = pcnt + 1;
        while (!fin) begin
            st = 1'b0;
            sl = stall_lf;
            x  = mk(2'd0, 0, 0, 1'b0, 1'b0, ifft, 1'b1, 1'b0);
            if (e == abort_e) begin
                step(1'b0, 1'b0, 1'b0, {name, "_rst"}, mk(2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                fin = 1'b1;
            end else begin
                if (e == 0) begin
                    st = 1'b1;
                end else if (e <= LC) begin
                    x.ld = 1'b1;
                    st = poke && (e == 1);
                end else if (issued < SN * CPS) begin
                    sl = (e >= st_from) && (e < st_from + st_len);
                    st = poke && (e == 5);
                    if (sl) begin
                        x.stg = lst[0];
                        x.cnt = lcn[1:0];
                    end else begin
                        lst = issued / CPS;
                        lcn = issued % CPS;
                        x.ms  = 2'd1;
                        x.v   = 1'b1;
                        x.stg = lst[0];
                        x.cnt = lcn[1:0];
                        issued++;
                    end
                end else if (fl < PL) begin
                    fl++;
                end else if (!dn_seen) begin
                    x.done = 1'b1;
                    dn_seen = 1'b1;
                end else begin
                    x = mk(2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    st = poke;
                    fin = 1'b1;
                end
                step(st, sl, 1'b1, name, x);
                e++;
            end
        end
        if (abort_e < 0) begin
            @(negedge clk);
            #1;
            chk({name, "_latency"}, done_edge - start_edge, 1 + LC + SN * CPS + PL + st_len);
            chk({name, "_issues"}, iss, SN * CPS);
            chk({name, "_one_done"}, n_done - nd0, 1);
        end
    endtask

    initial begin
        exp_t z;
        int   nd_before;
        int   s0;
        z = mk(2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) step(1'b0, 1'b0, 1'b0, "reset", z);
        repeat (2) step(1'b0, 1'b0, 1'b1, "idle", z);

        pass(1'b1, 0, 0, 1'b0, 1'b0, -1, "p1_basic");
        repeat (2) step(1'b0, 1'b0, 1'b1, "idle", z);

        pass(1'b0, 6, 3, 1'b0, 1'b0, -1, "p2_stall");
        step(1'b0, 1'b0, 1'b1, "idle", z);

        pass(1'b1, 0, 0, 1'b0, 1'b1, -1, "p3_poke");
        pass(1'b0, 0, 0, 1'b0, 1'b0, -1, "p3_next");
        step(1'b0, 1'b0, 1'b1, "idle", z);

        nd_before = n_done;
        pass(1'b1, 0, 0, 1'b0, 1'b0, 9, "p4_abort");
        repeat (4) step(1'b0, 1'b0, 1'b1, "p4_idle", z);
        @(negedge clk);
        #1;
        chk("p4_no_done", n_done - nd_before, 0);
        pass(1'b0, 0, 0, 1'b0, 1'b0, -1, "p4_clean");
        step(1'b0, 1'b0, 1'b1, "idle", z);

        pass(1'b1, 4, 2, 1'b1, 1'b0, -1, "p5_stall_lf");
        step(1'b0, 1'b0, 1'b1, "idle", z);

        ifft_mode = 1'b0;
        iss0 = 0;
        s0 = pcnt + 1;
        start0 = 1'b1;
        step(1'b0, 1'b0, 1'b1, "p6_idle", z);
        start0 = 1'b0;
        repeat (14) step(1'b0, 1'b0, 1'b1, "p6_idle", z);
        @(negedge clk);
        #1;
        chk("p6_latency", done0_edge - s0, 1 + LC + SN * CPS);
        chk("p6_issues", iss0, SN * CPS);
        chk("p6_issue_to_done", done0_edge - last_v0, 1);
        chk("p6_one_done", n_done0, 1);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
